// File: rtl/e_stage_md.sv
// Execute stage of the 5-stage MIPS pipeline: D->E pipe registers, rs/rt forwarding,
// ALU result C, and (with MD_UNIT_EN defined) a multi-cycle mult/div unit with HI/LO.
module e_stage_md #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_E,
  input  logic [31:0] IR_D,
  input  logic [31:0] PC8_D,
  input  logic [31:0] RS_D,
  input  logic [31:0] RT_D,
  input  logic [31:0] EXT_D,
  input  logic [1:0]  FRSE,
  input  logic [1:0]  FRTE,
  input  logic [31:0] WD,
  input  logic [31:0] C_M,
  output logic [31:0] IR_E,
  output logic [31:0] PC8_E,
  output logic [31:0] RT_E,
  output logic [31:0] C,
  output logic        Start,
  output logic        Busy
);

  logic [31:0] ir_q, pc8_q, rs_q, rt_q, ext_q;
  logic [31:0] rs_f, rt_f;
  logic [5:0]  op, funct;

  // No enable: stalls are realised by the hazard unit flushing E.
  always_ff @(posedge clk) begin
    if (reset || clr_E) begin
      ir_q  <= '0;
      pc8_q <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      ext_q <= '0;
    end else begin
      ir_q  <= IR_D;
      pc8_q <= PC8_D;
      rs_q  <= RS_D;
      rt_q  <= RT_D;
      ext_q <= EXT_D;
    end
  end

  always_comb begin
    case (FRSE)
      2'd1:    rs_f = WD;
      2'd2:    rs_f = C_M;
      default: rs_f = rs_q;
    endcase
    case (FRTE)
      2'd1:    rt_f = WD;
      2'd2:    rt_f = C_M;
      default: rt_f = rt_q;
    endcase
  end

  assign op    = ir_q[31:26];
  assign funct = ir_q[5:0];
  assign IR_E  = ir_q;
  assign PC8_E = pc8_q;
  assign RT_E  = rt_f;

`ifdef MD_UNIT_EN
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [63:0]      tmp_q, tmp_d;
  logic             dz_q, dz_d;
  logic             md_op, is_div, is_uns;
  logic [63:0]      prod;
  logic [31:0]      a_mag, b_mag, b_div, q_mag, r_mag, div_q, div_r;

  assign md_op  = (op == 6'h00) && (funct[5:2] == 4'b0110);
  assign is_div = funct[1];
  assign is_uns = funct[0];
  assign Start  = md_op;
  assign Busy   = (cnt_q != '0);

  // Divide on magnitudes so the most-negative/-1 case cannot trap and rem follows dividend.
  always_comb begin
    if (is_uns) prod = {32'b0, rs_f} * {32'b0, rt_f};
    else        prod = {{32{rs_f[31]}}, rs_f} * {{32{rt_f[31]}}, rt_f};
    a_mag = (!is_uns && rs_f[31]) ? (32'd0 - rs_f) : rs_f;
    b_mag = (!is_uns && rt_f[31]) ? (32'd0 - rt_f) : rt_f;
    b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag = a_mag / b_div;
    r_mag = a_mag % b_div;
    div_q = (!is_uns && (rs_f[31] ^ rt_f[31])) ? (32'd0 - q_mag) : q_mag;
    div_r = (!is_uns && rs_f[31]) ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    tmp_d = tmp_q;
    dz_d  = dz_q;
    if (Busy) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && !dz_q) {hi_d, lo_d} = tmp_q;
    end else if (md_op) begin
      cnt_d = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      tmp_d = is_div ? {div_r, div_q} : prod;
      dz_d  = is_div && (rt_f == 32'd0);
    end else if (op == 6'h00 && funct == 6'h11) begin
      hi_d = rs_f;
    end else if (op == 6'h00 && funct == 6'h13) begin
      lo_d = rs_f;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      tmp_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      tmp_q <= tmp_d;
      dz_q  <= dz_d;
    end
  end
`else
  assign Start = 1'b0;
  assign Busy  = 1'b0;
`endif

  always_comb begin
    C = '0;
    case (op)
      6'h00: begin
        case (funct)
          6'h21:   C = rs_f + rt_f;
          6'h23:   C = rs_f - rt_f;
          6'h24:   C = rs_f & rt_f;
          6'h25:   C = rs_f | rt_f;
          6'h2A:   C = {31'b0, $signed(rs_f) < $signed(rt_f)};
          6'h2B:   C = {31'b0, rs_f < rt_f};
          6'h00:   C = rt_f << ir_q[10:6];
`ifdef MD_UNIT_EN
          6'h10:   C = hi_q;
          6'h12:   C = lo_q;
`endif
          default: C = '0;
        endcase
      end
      6'h0D:   C = rs_f | ext_q;
      6'h0F:   C = {ext_q[15:0], 16'b0};
      6'h23,
      6'h2B:   C = rs_f + ext_q;
      6'h03:   C = pc8_q;
      default: C = '0;
    endcase
  end

endmodule

// File: tb/tb_e_stage_md.sv
// Self-checking bench for e_stage_md; follows MD_UNIT_EN so either build is checked.
module tb_e_stage_md;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
`ifdef MD_UNIT_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, clr_E;
  logic [31:0] IR_D, PC8_D, RS_D, RT_D, EXT_D, WD, C_M;
  logic [1:0]  FRSE, FRTE;
  logic [31:0] IR_E, PC8_E, RT_E, C;
  logic        Start, Busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  e_stage_md #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .clr_E(clr_E), .IR_D(IR_D), .PC8_D(PC8_D),
    .RS_D(RS_D), .RT_D(RT_D), .EXT_D(EXT_D), .FRSE(FRSE), .FRTE(FRTE),
    .WD(WD), .C_M(C_M), .IR_E(IR_E), .PC8_E(PC8_E), .RT_E(RT_E), .C(C),
    .Start(Start), .Busy(Busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_r(input logic [5:0] fn, input logic [4:0] sh);
    return {6'h00, 5'd1, 5'd2, 5'd3, sh, fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] opc, input logic [15:0] imm);
    return {opc, 5'd1, 5'd2, imm};
  endfunction

  // Expected C from the instruction-set definition.
  function automatic logic [31:0] c_ref(input logic [31:0] ir, pc8, rsf, rtf, ext);
    logic [5:0] opc = ir[31:26];
    logic [5:0] fn  = ir[5:0];
    int sh = ir[10:6];
    if (opc == 6'h00) begin
      if (fn == 6'h21) return rsf + rtf;
      if (fn == 6'h23) return rsf - rtf;
      if (fn == 6'h24) return rsf & rtf;
      if (fn == 6'h25) return rsf | rtf;
      if (fn == 6'h2A) return (int'(rsf) < int'(rtf)) ? 32'd1 : 32'd0;
      if (fn == 6'h2B) return (longint'(rsf) < longint'(rtf)) ? 32'd1 : 32'd0;
      if (fn == 6'h00) return rtf * (32'd1 << sh);
      if (fn == 6'h10) return m_hi;
      if (fn == 6'h12) return m_lo;
      return 32'd0;
    end
    if (opc == 6'h0D) return rsf | ext;
    if (opc == 6'h0F) return ext * 32'h0001_0000;
    if (opc == 6'h23 || opc == 6'h2B) return rsf + ext;
    if (opc == 6'h03) return pc8;
    return 32'd0;
  endfunction

  // HI/LO after an md instruction completes.
  task automatic md_ref(input logic [5:0] fn, input logic [31:0] rs, rt);
    longint a, b, p;
    longint unsigned pu;
    if (!MD_EN) return;
    case (fn)
      6'h18: begin a = int'(rs); b = int'(rt); p = a * b; m_hi = p[63:32]; m_lo = p[31:0]; end
      6'h19: begin pu = longint'(rs) * longint'(rt); m_hi = pu[63:32]; m_lo = pu[31:0]; end
      6'h1A: if (rt != 0) begin
        a = int'(rs); b = int'(rt); p = a / b; m_lo = p[31:0]; p = a % b; m_hi = p[31:0];
      end
      6'h1B: if (rt != 0) begin m_lo = rs / rt; m_hi = rs % rt; end
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk_cnt++;
    if ((Start && Busy) !== 1'b0)
      $display("FAIL md_in_E_while_busy: Start=%b Busy=%b required not both 1", Start, Busy);
    else pass_cnt++;
  endtask

  task automatic idle_inputs();
    clr_E = 0; IR_D = 0; PC8_D = 0; RS_D = 0; RT_D = 0; EXT_D = 0;
    FRSE = 0; FRTE = 0; WD = 0; C_M = 0;
  endtask

  task automatic check_hilo(input string tag);
    IR_D = mk_r(6'h10, 0); step();
    chk_cnt++;
    if (C !== m_hi) $display("FAIL %s_mfhi: got %h required %h", tag, C, m_hi); else pass_cnt++;
    IR_D = mk_r(6'h12, 0); step();
    chk_cnt++;
    if (C !== m_lo) $display("FAIL %s_mflo: got %h required %h", tag, C, m_lo); else pass_cnt++;
    IR_D = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; IR_D = mk_i(6'h0D, 16'h1234); EXT_D = 32'h0000_1234;
    step(); step();
    chk_cnt++;
    if (IR_E !== 0 || C !== 0 || Busy !== 0 || RT_E !== 0 || PC8_E !== 0)
      $display("FAIL reset_state: IR_E=%h C=%h Busy=%b RT_E=%h PC8_E=%h required all 0",
               IR_E, C, Busy, RT_E, PC8_E);
    else pass_cnt++;
    reset = 0; step();
    chk_cnt++;
    if (C !== 32'h1234 || IR_E !== mk_i(6'h0D, 16'h1234) || Busy !== 0 || Start !== 0)
      $display("FAIL reset_ori: C=%h IR_E=%h Busy=%b Start=%b required C=00001234", C, IR_E, Busy, Start);
    else pass_cnt++;
  endtask

  task automatic test_forward();
    idle_inputs();
    IR_D = mk_r(6'h21, 0); RS_D = 5; RT_D = 7; step();
    FRSE = 2; C_M = 32'h10; FRTE = 1; WD = 32'hFFFF_FFFF; #1;
    chk_cnt++;
    if (C !== 32'h0000_000F || RT_E !== 32'hFFFF_FFFF)
      $display("FAIL fwd_addu: C=%h RT_E=%h required 0000000f ffffffff", C, RT_E);
    else pass_cnt++;
    FRSE = 3; FRTE = 3; #1;
    chk_cnt++;
    if (C !== 32'd12 || RT_E !== 32'd7)
      $display("FAIL fwd_sel3: C=%h RT_E=%h required 0000000c 00000007", C, RT_E);
    else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_random_alu();
    logic [5:0] rfn [8] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h00, 6'h27};
    logic [5:0] iop [6] = '{6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h03, 6'h3E};
    logic [31:0] ir, rsf, rtf, exp_c;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(1, 0) == 1) ir = mk_r(rfn[$urandom_range(7, 0)], 5'($urandom_range(31, 0)));
      else ir = mk_i(iop[$urandom_range(5, 0)], 16'($urandom));
      IR_D = ir; RS_D = $urandom; RT_D = $urandom; EXT_D = $urandom; PC8_D = $urandom;
      if (i % 4 == 0) begin RS_D = RT_D; end
      step();
      FRSE = 2'($urandom_range(3, 0)); FRTE = 2'($urandom_range(3, 0));
      WD = $urandom; C_M = $urandom; #1;
      rsf = (FRSE == 1) ? WD : (FRSE == 2) ? C_M : RS_D;
      rtf = (FRTE == 1) ? WD : (FRTE == 2) ? C_M : RT_D;
      exp_c = c_ref(ir, PC8_D, rsf, rtf, EXT_D);
      chk_cnt++;
      if (C !== exp_c || RT_E !== rtf || IR_E !== ir || PC8_E !== PC8_D)
        $display("FAIL rand_alu[%0d] ir=%h: C=%h RT_E=%h IR_E=%h required C=%h RT_E=%h",
                 i, ir, C, RT_E, IR_E, exp_c, rtf);
      else pass_cnt++;
    end
    idle_inputs();
  endtask

  task automatic run_md(input string tag, input logic [5:0] fn, input logic [31:0] rs, rt);
    int cnt, exp_n;
    logic [31:0] old_hi;
    exp_n = !MD_EN ? 0 : (fn[1] ? DIV_N : MULT_N);
    old_hi = m_hi;
    IR_D = mk_r(fn, 0); RS_D = rs; RT_D = rt; FRSE = 0; FRTE = 0;
    step();
    chk_cnt++;
    if (Start !== MD_EN || Busy !== 0 || C !== 0)
      $display("FAIL %s_start: Start=%b Busy=%b C=%h required Start=%b Busy=0 C=0", tag, Start, Busy, C, MD_EN);
    else pass_cnt++;
    IR_D = mk_r(6'h10, 0); RS_D = 0; RT_D = 0;
    step();
    chk_cnt++;
    if (C !== old_hi || Start !== 0)
      $display("FAIL %s_mfhi_busy: C=%h Start=%b required %h 0", tag, C, Start, old_hi);
    else pass_cnt++;
    IR_D = 0; cnt = 0;
    while (Busy === 1'b1 && cnt < 100) begin cnt++; step(); end
    chk_cnt++;
    if (cnt !== exp_n) $display("FAIL %s_busy_len: got %0d cycles required %0d", tag, cnt, exp_n);
    else pass_cnt++;
    md_ref(fn, rs, rt);
    check_hilo(tag);
  endtask

  task automatic test_md_directed();
    idle_inputs();
    run_md("mult", 6'h18, 32'hFFFF_FFFE, 32'd3);
    run_md("div", 6'h1A, 32'hFFFF_FFF9, 32'd2);
    run_md("divu0", 6'h1B, 32'h1234_5678, 32'd0);
    run_md("multu", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_md("divu", 6'h1B, 32'hFFFF_FFF9, 32'd2);
  endtask

  task automatic test_md_random();
    logic [31:0] rs, rt;
    for (int i = 0; i < 8; i++) begin
      rs = $urandom; rt = (i == 3) ? 32'd0 : $urandom_range(i, 0) == 0 ? $urandom : 32'($urandom_range(300, 1));
      if (i % 2 == 1) rt = 32'd0 - rt;
      run_md("md_rand", 6'(6'h18 + (i % 4)), rs, rt);
    end
  endtask

  task automatic test_flush_jal();
    idle_inputs();
    IR_D = mk_r(6'h11, 0); RS_D = 32'hA5A5_A5A5; step();
    IR_D = mk_i(6'h03, 16'h0); PC8_D = 32'h3008; RS_D = 0; clr_E = 1; step();
    chk_cnt++;
    if (IR_E !== 0 || C !== 0 || PC8_E !== 0)
      $display("FAIL flush_jal: IR_E=%h C=%h PC8_E=%h required 0 0 0", IR_E, C, PC8_E);
    else pass_cnt++;
    clr_E = 0;
    if (MD_EN) m_hi = 32'hA5A5_A5A5;
    IR_D = mk_r(6'h13, 0); RS_D = 32'h5A5A_0F0F; step();
    if (MD_EN) m_lo = 32'h5A5A_0F0F;
    RS_D = 0;
    check_hilo("mthi_mtlo");
    IR_D = mk_i(6'h03, 16'h0); PC8_D = 32'h3008; step();
    chk_cnt++;
    if (C !== 32'h3008 || PC8_E !== 32'h3008)
      $display("FAIL jal_link: C=%h PC8_E=%h required 00003008", C, PC8_E);
    else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_reset_mid_div();
    int late_busy;
    idle_inputs();
    IR_D = mk_r(6'h1A, 0); RS_D = 32'd100; RT_D = 32'd7; step();
    IR_D = 0; RS_D = 0; RT_D = 0;
    for (int k = 0; k < 4; k++) step();
    chk_cnt++;
    if (Busy !== MD_EN) $display("FAIL mid_div_busy: Busy=%b required %b", Busy, MD_EN);
    else pass_cnt++;
    reset = 1; step(); reset = 0;
    chk_cnt++;
    if (Busy !== 0) $display("FAIL reset_abort: Busy=%b required 0", Busy);
    else pass_cnt++;
    late_busy = 0;
    for (int k = 0; k < 12; k++) begin step(); if (Busy !== 1'b0) late_busy++; end
    chk_cnt++;
    if (late_busy !== 0) $display("FAIL reset_abort_late: Busy seen %0d cycles required 0", late_busy);
    else pass_cnt++;
    m_hi = 0; m_lo = 0;
    check_hilo("reset_abort");
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_forward();
    test_random_alu();
    test_md_directed();
    test_flush_jal();
    test_md_random();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
